// File: rtl/vga_tile_framebuffer.sv
// Down-scaled tile framebuffer between vga_driver and the VGA pins.
// Pattern fill engine, host write port and 2-cycle pixel read path.
module vga_tile_framebuffer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SCALE_SHIFT = 2,
  parameter int CH_W = 8,
  parameter logic [3*CH_W-1:0] BUSY_COLOR = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              active_pixels,
  input  logic              frame_done,
  input  logic              fill_start,
  input  logic [1:0]        fill_mode,
  input  logic [2:0]        fill_mask,
  input  logic [3*CH_W-1:0] fill_color,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_x,
  input  logic [7:0]        wr_y,
  input  logic [3*CH_W-1:0] wr_data,
  output logic              busy,
  output logic              pix_valid,
  output logic [CH_W-1:0]   pix_r,
  output logic [CH_W-1:0]   pix_g,
  output logic [CH_W-1:0]   pix_b
);

  localparam int COLOR_W = 3 * CH_W;
  localparam int MEM_W = H_ACTIVE >> SCALE_SHIFT;
  localparam int MEM_H = V_ACTIVE >> SCALE_SHIFT;
  localparam int DEPTH = MEM_W * MEM_H;
  localparam int AW = $clog2(DEPTH);
  localparam int XW = $clog2(MEM_W);
  localparam int YW = $clog2(MEM_H);

  typedef enum logic [1:0] {
    S_FILL,
    S_DISPLAY,
    S_PEND
  } state_t;

  state_t state, state_nx;

  logic [XW-1:0]      bx;
  logic [YW-1:0]      by;
  logic [AW-1:0]      fill_addr;
  logic [1:0]         sh_mode;
  logic [2:0]         sh_mask;
  logic [COLOR_W-1:0] sh_color;
  logic [COLOR_W-1:0] pat;
  logic [CH_W-1:0]    gcol;
  logic [CH_W-1:0]    gr, gg, gb;
  logic               x_last;
  logic               fill_last;
  logic               fill_go;

  logic               wr_in;
  logic [AW-1:0]      wr_addr;
  logic               we;
  logic [AW-1:0]      wa;
  logic [COLOR_W-1:0] wd;

  logic               in_vis;
  logic [AW-1:0]      cur_addr;
  logic [AW-1:0]      hold_addr;
  logic [AW-1:0]      rd_addr;
  logic [COLOR_W-1:0] ram_q;
  logic [COLOR_W-1:0] mem [DEPTH];
  logic               act_d1;
  logic [COLOR_W-1:0] pix_nx;

  assign x_last    = (bx == XW'(MEM_W - 1));
  assign fill_last = x_last && (by == YW'(MEM_H - 1));
  assign fill_go   = (state == S_PEND) && frame_done;
  assign busy      = (state != S_DISPLAY);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FILL:    if (fill_last) state_nx = S_DISPLAY;
      S_DISPLAY: if (fill_start) state_nx = S_PEND;
      S_PEND:    if (frame_done) state_nx = S_FILL;
      default:   state_nx = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_nx;
  end

  // Shadow regs freeze the pattern for the whole fill.
  always_ff @(posedge clk) begin
    if (rst || fill_go) begin
      bx        <= '0;
      by        <= '0;
      fill_addr <= '0;
      sh_mode   <= fill_mode;
      sh_mask   <= fill_mask;
      sh_color  <= fill_color;
    end else if (state == S_FILL) begin
      if (fill_last) begin
        bx        <= '0;
        by        <= '0;
        fill_addr <= '0;
      end else begin
        fill_addr <= fill_addr + AW'(1);
        if (x_last) begin
          bx <= '0;
          by <= by + YW'(1);
        end else begin
          bx <= bx + XW'(1);
        end
      end
    end
  end

  assign gcol = CH_W'(bx);

  always_comb begin
    gr  = sh_mask[2] ? gcol : '0;
    gg  = sh_mask[1] ? gcol : '0;
    gb  = sh_mask[0] ? gcol : '0;
    pat = sh_color;
    unique case (sh_mode)
      2'd0:    pat = sh_color;
      2'd1:    pat = {gr, gg, gb};
      2'd2:    pat = (bx[0] ^ by[0]) ? sh_color : '0;
      2'd3:    pat = bx[3] ? sh_color : ~sh_color;
      default: pat = sh_color;
    endcase
  end

  assign wr_ready = wr_valid & (state == S_DISPLAY) & ~rst;
  assign wr_in = (32'(wr_x) < MEM_W) && (32'(wr_y) < MEM_H);
  assign wr_addr = AW'(wr_y) * AW'(MEM_W) + AW'(wr_x);

  assign we = ~rst & ((state == S_FILL) | (wr_ready & wr_in));
  assign wa = (state == S_FILL) ? fill_addr : wr_addr;
  assign wd = (state == S_FILL) ? pat : wr_data;

  assign in_vis = (32'(x) < H_ACTIVE) && (32'(y) < V_ACTIVE);
  assign cur_addr = AW'(y >> SCALE_SHIFT) * AW'(MEM_W)
                  + AW'(x >> SCALE_SHIFT);
  assign rd_addr = in_vis ? cur_addr : hold_addr;

  always_ff @(posedge clk) begin
    if (rst)         hold_addr <= '0;
    else if (in_vis) hold_addr <= cur_addr;
  end

  // Read-before-write: a same-address write shows up one read later.
  always_ff @(posedge clk) begin
    ram_q <= mem[rd_addr];
    if (we) mem[wa] <= wd;
  end

  always_comb begin
    pix_nx = ram_q;
    if (!act_d1)              pix_nx = '0;
    else if (state == S_FILL) pix_nx = BUSY_COLOR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_d1    <= 1'b0;
      pix_valid <= 1'b0;
      pix_r     <= '0;
      pix_g     <= '0;
      pix_b     <= '0;
    end else begin
      act_d1    <= active_pixels;
      pix_valid <= act_d1;
      {pix_r, pix_g, pix_b} <= pix_nx;
    end
  end

endmodule

// File: tb/tb_vga_tile_framebuffer.sv
// Directed bench for vga_tile_framebuffer: fills, host writes,
// pending fills, read latency and reset during a fill.
module tb_vga_tile_framebuffer;

  localparam int MEM_W = 160;
  localparam int MEM_H = 120;
  localparam int N = MEM_W * MEM_H;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x, y;
  logic        active_pixels;
  logic        frame_done;
  logic        fill_start;
  logic [1:0]  fill_mode;
  logic [2:0]  fill_mask;
  logic [23:0] fill_color;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_x, wr_y;
  logic [23:0] wr_data;
  logic        busy;
  logic        pix_valid;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [23:0] pix;

  int vectors = 0;
  int fails = 0;
  logic [23:0] exp_mem [N];

  assign pix = {pix_r, pix_g, pix_b};

  always #5 clk = ~clk;

  vga_tile_framebuffer dut (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .active_pixels(active_pixels), .frame_done(frame_done),
    .fill_start(fill_start), .fill_mode(fill_mode),
    .fill_mask(fill_mask), .fill_color(fill_color),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .busy(busy), .pix_valid(pix_valid),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b)
  );

  function automatic void model_fill(input logic [1:0] m,
                                     input logic [2:0] k,
                                     input logic [23:0] c);
    for (int t = 0; t < N; t++) begin
      int tx = t % MEM_W;
      int ty = t / MEM_W;
      logic [7:0] g = 8'(tx);
      case (m)
        2'd0: exp_mem[t] = c;
        2'd1: exp_mem[t] = {k[2] ? g : 8'h00, k[1] ? g : 8'h00,
                            k[0] ? g : 8'h00};
        2'd2: exp_mem[t] = (((tx + ty) % 2) == 1) ? c : 24'h0;
        default: exp_mem[t] = ((tx / 8) % 2 == 1) ? c : ~c;
      endcase
    end
  endfunction

  task automatic count_busy(input string name);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 30000) begin
      cnt++;
      @(negedge clk);
    end
    vectors++;
    if (cnt != 19200) begin
      fails++;
      $display("FAIL %s: busy cycles %0d, expected 19200", name, cnt);
    end
  endtask

  task automatic wait_idle(input int limit, input string name);
    int cnt = 0;
    while (busy !== 1'b0 && cnt < limit) begin
      cnt++;
      @(negedge clk);
    end
    vectors++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL %s: busy=%b after %0d cycles, expected 0",
               name, busy, cnt);
    end
  endtask

  task automatic check_bit(input logic got, input logic exp,
                           input string name);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_col(input logic [23:0] got,
                           input logic [23:0] exp,
                           input string name);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic write_px(input logic [7:0] wx, input logic [7:0] wy,
                          input logic [23:0] d, input logic rdy,
                          input string name);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_x = wx;
    wr_y = wy;
    wr_data = d;
    #1;
    check_bit(wr_ready, rdy, name);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic read_tile(input int tx, input int ty,
                           output logic [23:0] c, output logic v);
    @(negedge clk);
    x = 10'(tx * 4 + 1);
    y = 10'(ty * 4 + 2);
    active_pixels = 1'b1;
    @(negedge clk);
    active_pixels = 1'b0;
    @(negedge clk);
    c = pix;
    v = pix_valid;
  endtask

  task automatic check_range(input int first, input int n,
                             input string name);
    int bad = 0;
    int bad_idx = -1;
    logic [23:0] bad_got = 24'h0;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        int idx = first + i - 2;
        if (pix_valid !== 1'b1 || pix !== exp_mem[idx]) begin
          if (bad == 0) begin
            bad_idx = idx;
            bad_got = pix;
          end
          bad++;
        end
      end
      if (i < n) begin
        int t = first + i;
        x = 10'((t % MEM_W) * 4 + (t % 4));
        y = 10'((t / MEM_W) * 4 + ((t / 4) % 4));
        active_pixels = 1'b1;
      end else begin
        active_pixels = 1'b0;
      end
    end
    vectors++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d tiles wrong, first tile %0d got %h expected %h",
               name, bad, bad_idx, bad_got, exp_mem[bad_idx]);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    fill_start = 1'b1;
    @(negedge clk);
    fill_start = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fill_mode = 2'd0;
    fill_mask = 3'b000;
    fill_color = 24'h123456;
    wr_valid = 1'b1;
    active_pixels = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_bit(busy, 1'b1, "reset_busy");
    check_bit(wr_ready, 1'b0, "reset_wr_ready");
    check_bit(pix_valid, 1'b0, "reset_pix_valid");
    check_col(pix, 24'h0, "reset_pix");
    rst = 1'b0;
    wr_valid = 1'b0;
    active_pixels = 1'b0;
    model_fill(2'd0, 3'b000, 24'h123456);
    count_busy("reset_fill_len");
  endtask

  task automatic test_host_write();
    logic [23:0] c;
    logic v;
    write_px(8'd10, 8'd3, 24'hABCDEF, 1'b1, "wr_ready_display");
    exp_mem[3 * MEM_W + 10] = 24'hABCDEF;
    @(negedge clk);
    x = 10'd42;
    y = 10'd13;
    active_pixels = 1'b1;
    @(negedge clk);
    x = 10'd700;
    y = 10'd0;
    @(negedge clk);
    check_col(pix, 24'hABCDEF, "pix_42_13");
    check_bit(pix_valid, 1'b1, "pix_valid_lat2");
    @(negedge clk);
    check_col(pix, 24'hABCDEF, "hold_addr_x_oob");
    active_pixels = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_col(pix, 24'h0, "inactive_blank");
    check_bit(pix_valid, 1'b0, "inactive_valid");
    @(negedge clk);
    x = 10'd80;
    y = 10'd80;
    active_pixels = 1'b1;
    wr_valid = 1'b1;
    wr_x = 8'd20;
    wr_y = 8'd20;
    wr_data = 24'h0BADF0;
    @(negedge clk);
    wr_valid = 1'b0;
    active_pixels = 1'b0;
    @(negedge clk);
    check_col(pix, 24'h123456, "rw_collision_old");
    exp_mem[20 * MEM_W + 20] = 24'h0BADF0;
    read_tile(20, 20, c, v);
    check_col(c, 24'h0BADF0, "rw_collision_new");
  endtask

  task automatic test_out_of_range();
    write_px(8'd160, 8'd0, 24'h111111, 1'b1, "wr_ready_x160");
    write_px(8'd0, 8'd120, 24'h222222, 1'b1, "wr_ready_y120");
    write_px(8'd255, 8'd255, 24'h333333, 1'b1, "wr_ready_max");
    check_range(0, N, "oob_full_readback");
  endtask

  task automatic test_pend();
    logic [23:0] c;
    logic v;
    fill_mode = 2'd1;
    fill_mask = 3'b100;
    fill_color = 24'h000000;
    pulse_start();
    check_bit(busy, 1'b1, "busy_pend");
    write_px(8'd1, 8'd1, 24'hDEAD00, 1'b0, "wr_ready_pend");
    repeat (20) @(negedge clk);
    check_range(0, 3 * MEM_W, "pend_ram_unchanged");
    pulse_frame();
    model_fill(2'd1, 3'b100, 24'h000000);
    read_tile(5, 5, c, v);
    check_col(c, 24'hFFFFFF, "busy_color_fill");
    repeat (200) @(negedge clk);
    write_px(8'd0, 8'd0, 24'h777777, 1'b0, "wr_ready_fill");
    pulse_start();
    wait_idle(25000, "gradient_done");
    repeat (5) @(negedge clk);
    check_bit(busy, 1'b0, "fill_start_ignored_in_fill");
    read_tile(37, 5, c, v);
    check_col(c, 24'h250000, "gradient_37_5");
    read_tile(159, 7, c, v);
    check_col(c, 24'h9F0000, "gradient_159_7");
    check_range(0, MEM_W, "gradient_row0");
    check_range(5 * MEM_W, MEM_W, "gradient_row5");
    check_range(119 * MEM_W, MEM_W, "gradient_row119");
  endtask

  task automatic test_reset_mid_fill();
    logic [23:0] c;
    logic v;
    fill_mode = 2'd0;
    fill_color = 24'h00C0A0;
    @(negedge clk);
    fill_start = 1'b1;
    frame_done = 1'b1;
    @(negedge clk);
    fill_start = 1'b0;
    frame_done = 1'b0;
    check_bit(busy, 1'b1, "start_with_frame_done");
    repeat (10) @(negedge clk);
    read_tile(37, 5, c, v);
    check_col(c, 24'h250000, "pend_until_next_frame");
    pulse_frame();
    repeat (5000) @(negedge clk);
    fill_mode = 2'd2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_fill(2'd2, 3'b000, 24'h00C0A0);
    count_busy("refill_len");
    read_tile(0, 0, c, v);
    check_col(c, 24'h000000, "checker_0_0");
    read_tile(1, 0, c, v);
    check_col(c, 24'h00C0A0, "checker_1_0");
    check_range(0, 2 * MEM_W, "checker_rows01");
    check_range(119 * MEM_W, MEM_W, "checker_row119");
  endtask

  initial begin
    rst = 1'b1;
    x = '0;
    y = '0;
    active_pixels = 1'b0;
    frame_done = 1'b0;
    fill_start = 1'b0;
    fill_mode = 2'd0;
    fill_mask = 3'b000;
    fill_color = 24'h0;
    wr_valid = 1'b0;
    wr_x = '0;
    wr_y = '0;
    wr_data = '0;
    test_reset();
    test_host_write();
    test_out_of_range();
    test_pend();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
